// File: rtl/ifetch_112_pkg.sv
// Shared definitions for the ifetch_112 fetch stage: FSM state encoding, MIPS opcode/func
// constants used around fetch, default reset PC / halt word, and the branch-offset helper.
package ifetch_112_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [5:0]  OP_RTYPE = 6'h00;
    localparam logic [5:0]  OP_J     = 6'h02;
    localparam logic [5:0]  OP_BEQ   = 6'h04;
    localparam logic [5:0]  OP_ADDI  = 6'h08;
    localparam logic [5:0]  FUNC_SYSCALL = 6'h0C;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INST = 32'h0000_000C;

    // Sign-extended word offset of a conditional branch, already scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_112_npc.sv
// npc_112: combinational next-PC selection (jump > taken branch > sequential), all mod 2^32.
module npc_112
    import ifetch_112_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] imm26,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] npc
);

    logic [31:0] pc4;

    assign pc4 = pc + 32'd4;

    // The branch immediate is the low half of the jump field.
    always_comb begin
        npc = pc4;
        if (jump) begin
            npc = {pc4[31:28], imm26, 2'b00};
        end else if (branch && zero) begin
            npc = pc4 + branch_offset(imm26[15:0]);
        end
    end

endmodule

// File: rtl/ifetch_112.sv
// ifetch_112: PC register and FETCH/EXEC/HALT sequencing over a ready-handshake instruction port.
// Optional fetch halt on HALT_INST is enabled by defining IFETCH_HALT_EN.
module ifetch_112
    import ifetch_112_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_INST = DEFAULT_HALT_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        inst_valid,
    output logic [31:0] pc,
    input  logic        retire,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic        halted
);

`ifdef IFETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    fetch_state_t state, state_next;
    logic [31:0]  pc_q, inst_q, npc;
    logic         inst_valid_q, halted_q;
    logic         halt_hit;

    assign halt_hit = HALT_EN && (imem_rdata == HALT_INST);

    npc_112 u_npc (
        .pc     (pc_q),
        .imm26  (inst_q[25:0]),
        .branch (Branch),
        .jump   (Jump),
        .zero   (Zero),
        .npc    (npc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, regardless of the order blocks are evaluated in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_next = halt_hit ? ST_HALT : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (retire) begin
                    state_next = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_next = ST_FETCH;
        endcase
    end

    // Handshake inputs are only acted on in the state that owns them; others are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= {RESET_PC[31:2], 2'b00};
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (halt_hit) begin
                            halted_q <= 1'b1;
                        end else begin
                            inst_q       <= imem_rdata;
                            inst_valid_q <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (retire) begin
                        pc_q         <= npc;
                        inst_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign op         = inst_q[31:26];
    assign func       = inst_q[5:0];
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;

endmodule
